// File: rtl/seg7_pkg.sv
// Shared segment patterns and idle constants for the 4-digit scanner.
// Patterns are {a,b,c,d,e,f,g}, active-low.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001101;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0001100;
   localparam logic [6:0] SEG_MINUS = 7'b1111110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [7:0] LED_OFF = 8'hFF;
   localparam logic [3:0] AN_OFF  = 4'b1111;

endpackage

// File: rtl/seg7_digit_dec.sv
// BCD-to-segment decoder; codes 10..15 render as a minus sign.
module seg7_digit_dec
   import seg7_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_MINUS;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_MINUS;
      endcase
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with frame-aligned LOAD/READY commit.
// Define SEG7_LZ_BLANK_EN to enable leading-zero suppression.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 500
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [15:0] VALUE,
   input  logic [3:0]  DP,
   input  logic        LOAD,
   output logic        READY,
   output logic [7:0]  LED,
   output logic [3:0]  AN
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK   = CW'(BLANK_CYC);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [15:0]   shadow_q, shadow_d;
   logic [3:0]    sdp_q, sdp_d;
   logic [15:0]   pend_q, pend_d;
   logic [3:0]    pdp_q, pdp_d;
   logic          ready_q, ready_d;
   logic [7:0]    led_q, led_d;
   logic [3:0]    an_q, an_d;

   logic          wrap;
   logic [3:0]    dig_sel;
   logic [6:0]    seg;
   logic          lz;

   always_comb begin
      cnt_d    = cnt_q + CW'(1);
      idx_d    = idx_q;
      shadow_d = shadow_q;
      sdp_d    = sdp_q;
      pend_d   = pend_q;
      pdp_d    = pdp_q;
      ready_d  = ready_q;
      wrap     = (cnt_q == CNT_MAX);
      if (wrap) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
      end
      if (ready_q && LOAD) begin
         pend_d  = VALUE;
         pdp_d   = DP;
         ready_d = 1'b0;
      end
      // Commit only on the 3->0 wrap so a frame never mixes two values
      if (wrap && idx_q == 2'd3 && !ready_q) begin
         shadow_d = pend_q;
         sdp_d    = pdp_q;
         ready_d  = 1'b1;
      end
   end

   assign dig_sel = shadow_d[{idx_d, 2'b00} +: 4];

   seg7_digit_dec u_dec (
      .digit (dig_sel),
      .seg   (seg)
   );

   always_comb begin
      lz = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
      case (idx_d)
         2'd3:    lz = (shadow_d[15:12] == 4'd0);
         2'd2:    lz = (shadow_d[15:8] == 8'd0);
         2'd1:    lz = (shadow_d[15:4] == 12'd0);
         default: lz = 1'b0;
      endcase
`endif
   end

   // Outputs are computed from next state so they line up with cnt_q/idx_q
   always_comb begin
      an_d  = AN_OFF;
      led_d = LED_OFF;
      if (cnt_d >= BLANK) begin
         an_d  = ~(4'b0001 << idx_d);
         led_d = {(lz ? SEG_BLANK : seg), ~sdp_d[idx_d]};
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q    <= '0;
         idx_q    <= '0;
         shadow_q <= '0;
         sdp_q    <= '0;
         pend_q   <= '0;
         pdp_q    <= '0;
         ready_q  <= 1'b1;
         led_q    <= LED_OFF;
         an_q     <= AN_OFF;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         sdp_q    <= sdp_d;
         pend_q   <= pend_d;
         pdp_q    <= pdp_d;
         ready_q  <= ready_d;
         led_q    <= led_d;
         an_q     <= an_d;
      end
   end

   assign READY = ready_q;
   assign LED   = led_q;
   assign AN    = an_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2.
module tb_seg7_scan_ctrl;

   localparam int SD = 8;
   localparam int BC = 2;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [15:0] VALUE = '0;
   logic [3:0]  DP = '0;
   logic        LOAD = 1'b0;
   logic        READY;
   logic [7:0]  LED;
   logic [3:0]  AN;

   int n_chk  = 0;
   int n_pass = 0;
   int pos    = 0;

   always #5 CLK = ~CLK;

   seg7_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .VALUE (VALUE),
      .DP    (DP),
      .LOAD  (LOAD),
      .READY (READY),
      .LED   (LED),
      .AN    (AN)
   );

   function automatic logic [6:0] dec_ref(input logic [3:0] d);
      case (d)
         4'd0: return 7'b0000001;
         4'd1: return 7'b1001111;
         4'd2: return 7'b0010010;
         4'd3: return 7'b0000110;
         4'd4: return 7'b1001100;
         4'd5: return 7'b0100100;
         4'd6: return 7'b0100000;
         4'd7: return 7'b0001101;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0001100;
         default: return 7'b1111110;
      endcase
   endfunction

   function automatic logic [3:0] exp_an(input int p);
      int s = p / SD;
      int c = p % SD;
      if (c < BC) return 4'b1111;
      return ~(4'b0001 << s);
   endfunction

   function automatic logic [7:0] exp_led(input int p,
                                          input logic [15:0] v,
                                          input logic [3:0] d);
      int s = p / SD;
      int c = p % SD;
      logic [6:0] sg;
      if (c < BC) return 8'hFF;
      sg = dec_ref(v[s*4 +: 4]);
`ifdef SEG7_LZ_BLANK_EN
      if (s > 0 && (v >> (s*4)) == 16'd0) sg = 7'h7F;
`endif
      return {sg, ~d[s]};
   endfunction

   task automatic tick;
      @(posedge CLK);
      @(negedge CLK);
      pos = (pos + 1) % (4*SD);
   endtask

   task automatic test_reset;
      @(negedge CLK);
      RST = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_chk++;
         if (AN !== 4'hF || LED !== 8'hFF || READY !== 1'b1)
            $display("FAIL reset_hold AN=%b LED=%h RDY=%b want 1111/ff/1",
                     AN, LED, READY);
         else n_pass++;
      end
      RST = 1'b0;
      pos = 0;
      for (int k = 0; k < SD; k++) begin
         n_chk++;
         if (k < 2) begin
            if (AN !== 4'b1111 || LED !== 8'hFF)
               $display("FAIL reset_blank c=%0d AN=%b LED=%h want 1111/ff",
                        k, AN, LED);
            else n_pass++;
         end else begin
            if (AN !== 4'b1110 || LED !== 8'b00000011)
               $display("FAIL reset_show c=%0d AN=%b LED=%b want 1110/00000011",
                        k, AN, LED);
            else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_scan_order;
      for (int k = 0; k < 32; k++) begin
         n_chk++;
         if (AN !== exp_an(pos) || LED !== exp_led(pos, 16'h0, 4'h0))
            $display("FAIL scan pos=%0d AN=%b LED=%h want %b/%h",
                     pos, AN, LED, exp_an(pos), exp_led(pos, 16'h0, 4'h0));
         else n_pass++;
         n_chk++;
         if ($countones(~AN) > 1)
            $display("FAIL scan_twohot pos=%0d AN=%b want <=1 low", pos, AN);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_handshake;
      LOAD = 1'b1;
      VALUE = 16'h1234;
      DP = 4'b0100;
      tick();
      LOAD = 1'b0;
      n_chk++;
      if (READY !== 1'b0)
         $display("FAIL hs_ready_fall READY=%b want 0", READY);
      else n_pass++;
      for (int k = 0; k < 40 && pos != 0; k++) begin
         n_chk++;
         if (AN !== exp_an(pos) || LED !== exp_led(pos, 16'h0, 4'h0)
             || READY !== 1'b0)
            $display("FAIL hs_old pos=%0d AN=%b LED=%h RDY=%b want %b/%h/0",
                     pos, AN, LED, READY, exp_an(pos),
                     exp_led(pos, 16'h0, 4'h0));
         else n_pass++;
         tick();
      end
      n_chk++;
      if (READY !== 1'b1)
         $display("FAIL hs_ready_rise READY=%b want 1", READY);
      else n_pass++;
      for (int k = 0; k < 32; k++) begin
         n_chk++;
         if (AN !== exp_an(pos) || LED !== exp_led(pos, 16'h1234, 4'b0100))
            $display("FAIL hs_new pos=%0d AN=%b LED=%h want %b/%h",
                     pos, AN, LED, exp_an(pos),
                     exp_led(pos, 16'h1234, 4'b0100));
         else n_pass++;
         if (pos == 18) begin
            n_chk++;
            if (LED !== 8'b00100100)
               $display("FAIL hs_dig2_dp LED=%b want 00100100", LED);
            else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_ignored_load;
      LOAD = 1'b1;
      VALUE = 16'h1234;
      DP = 4'b0100;
      tick();
      VALUE = 16'h9999;
      DP = 4'b1111;
      tick();
      LOAD = 1'b0;
      n_chk++;
      if (READY !== 1'b0)
         $display("FAIL ign_ready READY=%b want 0", READY);
      else n_pass++;
      for (int k = 0; k < 62; k++) begin
         n_chk++;
         if (AN !== exp_an(pos) || LED !== exp_led(pos, 16'h1234, 4'b0100))
            $display("FAIL ign_disp pos=%0d AN=%b LED=%h want %b/%h",
                     pos, AN, LED, exp_an(pos),
                     exp_led(pos, 16'h1234, 4'b0100));
         else n_pass++;
         tick();
      end
      n_chk++;
      if (READY !== 1'b1)
         $display("FAIL ign_ready_end READY=%b want 1", READY);
      else n_pass++;
   endtask

   task automatic test_invalid_zero;
      LOAD = 1'b1;
      VALUE = 16'h00A5;
      DP = 4'b0000;
      tick();
      LOAD = 1'b0;
      for (int k = 0; k < 40 && pos != 0; k++) tick();
      for (int k = 0; k < 32; k++) begin
         n_chk++;
         if (AN !== exp_an(pos) || LED !== exp_led(pos, 16'h00A5, 4'b0))
            $display("FAIL inv_disp pos=%0d AN=%b LED=%h want %b/%h",
                     pos, AN, LED, exp_an(pos), exp_led(pos, 16'h00A5, 4'b0));
         else n_pass++;
         if (pos == 2) begin
            n_chk++;
            if (LED !== 8'h49)
               $display("FAIL inv_dig0 LED=%h want 49", LED);
            else n_pass++;
         end
         if (pos == 10) begin
            n_chk++;
            if (LED !== 8'hFD || AN !== 4'b1101)
               $display("FAIL inv_dig1 LED=%h AN=%b want fd/1101", LED, AN);
            else n_pass++;
         end
         if (pos == 26) begin
            n_chk++;
`ifdef SEG7_LZ_BLANK_EN
            if (LED !== 8'hFF || AN !== 4'b0111)
               $display("FAIL inv_lz_dig3 LED=%h AN=%b want ff/0111", LED, AN);
            else n_pass++;
`else
            if (LED !== 8'h03 || AN !== 4'b0111)
               $display("FAIL inv_dig3 LED=%h AN=%b want 03/0111", LED, AN);
            else n_pass++;
`endif
         end
         tick();
      end
   endtask

   task automatic test_reset_mid;
      LOAD = 1'b1;
      VALUE = 16'h5678;
      DP = 4'b1111;
      tick();
      LOAD = 1'b0;
      n_chk++;
      if (READY !== 1'b0)
         $display("FAIL rm_ready READY=%b want 0", READY);
      else n_pass++;
      repeat (5) tick();
      RST = 1'b1;
      tick();
      n_chk++;
      if (AN !== 4'hF || LED !== 8'hFF || READY !== 1'b1)
         $display("FAIL rm_reset AN=%b LED=%h RDY=%b want 1111/ff/1",
                  AN, LED, READY);
      else n_pass++;
      RST = 1'b0;
      pos = 0;
      for (int k = 0; k < 40; k++) begin
         n_chk++;
         if (AN !== exp_an(pos) || LED !== exp_led(pos, 16'h0, 4'h0)
             || READY !== 1'b1)
            $display("FAIL rm_disp pos=%0d AN=%b LED=%h RDY=%b want %b/%h/1",
                     pos, AN, LED, READY, exp_an(pos),
                     exp_led(pos, 16'h0, 4'h0));
         else n_pass++;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_scan_order();
      test_handshake();
      test_ignored_load();
      test_invalid_zero();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Four-digit multiplexed 7-segment display controller. It holds a 16-bit BCD value and time-multiplexes it onto one shared active-low segment bus and four active-low anodes. Each digit gets an anti-ghosting blank interval before it is driven. A LOAD/READY handshake commits new values only at a frame boundary, so the display never shows a partly updated number. It sits between the numeric datapath and the board display pins.

## Interface
- SCAN_DIV, 50000: clock cycles per digit slot; must be at least 2.
- BLANK_CYC, 500: blank cycles at the start of each slot; must satisfy 1 <= BLANK_CYC < SCAN_DIV.
- CLK  in  1  system clock. This block has one clock domain, CLK.
- RST  in  1  reset: synchronous and active-high.
- VALUE  in  16  four BCD digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- DP  in  4  decimal-point enables, one per digit; 1 means lit.
- LOAD  in  1  request to capture VALUE/DP. Sampled only while READY=1.
- READY  out  1  1 means a new LOAD is accepted.
- LED  out  8  segments {a,b,c,d,e,f,g,dp}, active-low.
- AN  out  4  digit anodes, active-low; AN[i] selects digit i.

## Operation
- Reset values:
  - AN=4'b1111, LED=8'hFF, READY=1.
  - Shadow value and pending value are 0; DP registers are 0.
  - Slot counter CNT=0, digit index IDX=0.
- Scan sequence:
  - CNT counts 0..SCAN_DIV-1. When CNT reaches SCAN_DIV-1, CNT returns to 0 and IDX advances 0→1→2→3→0.
  - Each slot has two phases:
    - BLANK, while CNT < BLANK_CYC: AN=4'b1111, LED=8'hFF.
    - SHOW, otherwise: AN drives digit IDX low and all others high; LED carries the decoded pattern of shadow digit IDX.
- Decoding, digits 0–9:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100.
  - 5 = 0100100, 6 = 0100000, 7 = 0001101, 8 = 0000000, 9 = 0001100.
- Decoding, digits 10–15: the pattern is the minus sign, 1111110.
- LED[0] = ~DP_shadow[IDX].
- Handshake:
  - LOAD while READY=1 captures VALUE and DP into the pending registers. READY goes 0 on the next cycle.
  - LOAD while READY=0 is ignored.
- Commit:
  - Happens on the cycle where IDX wraps 3→0, i.e. at CNT=SCAN_DIV-1 with IDX=3, and only if a value is pending.
  - Pending is copied to shadow, and READY returns to 1 on the next cycle.
  - A frame (digits 0..3) therefore always shows one value.
- RST asserted mid-scan or mid-handshake: all state returns to reset values on the next edge, and any pending value is discarded.

## Timing
- AN and LED are registered. They reflect the phase of the current CNT/IDX with no extra pipeline offset.
- Frame period is 4*SCAN_DIV cycles. Each digit is lit for SCAN_DIV-BLANK_CYC cycles per frame.
- The first lit digit after reset is digit 0, at CNT=BLANK_CYC.
- LOAD-to-display latency:
  - READY falls 1 cycle after LOAD.
  - The new value appears at the next frame start, BLANK_CYC cycles after the wrap.
  - Worst case is 4*SCAN_DIV+BLANK_CYC cycles.
- AN is never driven with two low bits, including across slot transitions.

## Configuration
- SEG7_LZ_BLANK_EN defined: leading-zero suppression.
  - Digit i in 3..1 is blanked (LED[7:1]=7'h7F) if shadow digits i..3 are all 0.
  - Its DP is still shown if enabled.
  - Digit 0 is never suppressed.
  - AN timing is unchanged.
- SEG7_LZ_BLANK_EN undefined: every digit is decoded as listed in Operation.

## Structure
- Shared package seg7_pkg holds:
  - the ten digit pattern constants and the minus-sign constant;
  - the all-off constant 8'hFF;
  - the anode-off constant 4'b1111.
- Sub-module seg7_digit_dec is a combinational BCD-to-segment decoder, instantiated once on the selected shadow digit.
- seg7_scan_ctrl holds the counter, IDX, the handshake registers and the output registers.

## Test plan
All scenarios use SCAN_DIV=8 and BLANK_CYC=2.
- Reset:
  - Stimulus: hold RST for 3 cycles, then release.
  - Required: AN=1111, LED=FF and READY=1 during reset. On cycles 2..7 after release, AN=1110 and LED=00000011 (shadow 0).
- Scan order:
  - Stimulus: free-run for 32 cycles.
  - Required: AN steps through 1110, 1101, 1011, 0111. Each step is 2 blank cycles followed by 6 lit cycles, and AN is never two-hot.
- Handshake:
  - Stimulus: pulse LOAD with VALUE=16'h1234 and DP=4'b0100 during IDX=1.
  - Required:
    - READY=0 on the next cycle.
    - The digits keep showing 0 until the wrap.
    - The next frame shows 4, 3, 2, 1.
    - Digit 2 has LED[0]=0.
    - READY=1 one cycle after the wrap.
- Ignored load:
  - Stimulus: a second LOAD with 16'h9999 while READY=0.
  - Required: the display shows 1234. 9999 never appears.
- Invalid and zero digits:
  - Stimulus: VALUE=16'h00A5.
  - Required: digit 1 shows 1111110 and digit 0 shows 0100100. With SEG7_LZ_BLANK_EN, digits 3 and 2 show LED=FF with their anodes still active.
- Reset mid-handshake:
  - Stimulus: LOAD 16'h5678, then assert RST before the wrap.
  - Required: reset values return, READY=1, and 5678 is never displayed.
